// File: rtl/sokoban_pkg.sv
// Shared Sokoban definitions: sprite ids, screen limits, render FSM encoding
// and bus widths used by the board renderer.
package sokoban_pkg;

  localparam logic [2:0] FLOOR          = 3'd0;
  localparam logic [2:0] WALL           = 3'd1;
  localparam logic [2:0] GOAL           = 3'd2;
  localparam logic [2:0] BOX            = 3'd3;
  localparam logic [2:0] BOX_ON_GOAL    = 3'd4;
  localparam logic [2:0] PLAYER         = 3'd5;
  localparam logic [2:0] PLAYER_ON_GOAL = 3'd6;
  localparam logic [2:0] EMPTY          = 3'd7;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned COL_W = 5;
  localparam int unsigned ROW_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    WAIT_DONE,
    ADVANCE,
    FINISH
  } render_state_t;

endpackage

// File: rtl/tile_cursor.sv
// Raster-order tile position: running col/row/address counters, no multiplier.
module tile_cursor
  import sokoban_pkg::*;
#(
  parameter int unsigned MAP_W  = 10,
  parameter int unsigned MAP_H  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              step,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap_c,
  output logic              last_tile_c
);

  assign wrap_c      = (col == COL_W'(MAP_W - 1));
  assign last_tile_c = wrap_c && (row == ROW_W'(MAP_H - 1));

  // step is never issued on the last tile, so row cannot run past MAP_H-1
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      if (wrap_c) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_render_sequencer.sv
// Walks the level map tile by tile and hands each non-empty tile to the
// sprite drawer, waiting for its completion before moving on.
module board_render_sequencer
  import sokoban_pkg::*;
#(
  parameter int unsigned MAP_W      = 10,
  parameter int unsigned MAP_H      = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TILE_SHIFT = 3,
  parameter int unsigned X_ORIGIN   = 0,
  parameter int unsigned Y_ORIGIN   = 0,
  parameter logic [2:0]  SKIP_ID    = EMPTY
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              map_rd_en,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [2:0]        map_data,
  output logic [7:0]        x_out,
  output logic [6:0]        y_out,
  output logic [2:0]        sprite_id_out,
  output logic              begin_draw,
  input  logic              draw_done
);

  render_state_t     state;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wrap_c;
  logic              cur_last_c;
  logic              cur_clear_c;
  logic              cur_step_c;
  logic [X_W-1:0]    tile_x_c;
  logic [Y_W-1:0]    tile_y_c;

  assign cur_clear_c = (state == IDLE) && start;
  assign cur_step_c  = (state == ADVANCE) && !cur_last_c;

  tile_cursor #(
    .MAP_W  (MAP_W),
    .MAP_H  (MAP_H),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (cur_clear_c),
    .step        (cur_step_c),
    .col         (cur_col),
    .row         (cur_row),
    .addr        (cur_addr),
    .wrap_c      (cur_wrap_c),
    .last_tile_c (cur_last_c)
  );

  // Cursor address is already a flop and is valid during FETCH
  assign map_addr = cur_addr;

  // Pixel position truncates to the screen bus widths
  assign tile_x_c = X_W'(X_ORIGIN) + (X_W'(cur_col) << TILE_SHIFT);
  assign tile_y_c = Y_W'(Y_ORIGIN) + (Y_W'(cur_row) << TILE_SHIFT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      map_rd_en     <= 1'b0;
      begin_draw    <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      sprite_id_out <= '0;
    end else begin
      frame_done <= 1'b0;
      map_rd_en  <= 1'b0;
      begin_draw <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            map_rd_en <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          // Empty tiles leave the previous draw request on the bus untouched
          if (map_data == SKIP_ID) begin
            state <= ADVANCE;
          end else begin
            sprite_id_out <= map_data;
            x_out         <= tile_x_c;
            y_out         <= tile_y_c;
            begin_draw    <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (draw_done) begin
            state <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (cur_last_c) begin
            state      <= FINISH;
            frame_done <= 1'b1;
          end else begin
            state     <= FETCH;
            map_rd_en <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/board_render_sequencer.md
Name: board_render_sequencer

Overview:
- Initiator side of the sprite draw request interface. Walks the Sokoban level tile map cell by cell and reads each tile's sprite id from the map RAM.
- For every tile, issues a draw request (x, y, sprite id, begin_draw) to the sprite drawer, then waits for its completion pulse before moving to the next tile.
- Sits between game logic, which pulses start after a board change, and the sprite_draw block, which owns the VGA adapter.

Parameters:
- MAP_W, 10, tiles per row (1..20).
- MAP_H, 8, tile rows (1..15).
- ADDR_W, 8, map address width; must satisfy 2^ADDR_W >= MAP_W*MAP_H.
- TILE_SHIFT, 3, log2 of tile edge in pixels (8 px tiles).
- X_ORIGIN, 0, pixel x of tile (0,0).
- Y_ORIGIN, 0, pixel y of tile (0,0).
- SKIP_ID, 3'd7, sprite id meaning "empty": no draw is issued for it.

Ports:
- clk, in, 1, system clock (CLOCK_50 domain).
- resetn, in, 1, synchronous active-low reset.
- start, in, 1, request one full board render; sampled only in IDLE.
- busy, out, 1, high in every state except IDLE.
- frame_done, out, 1, one-cycle pulse when the last tile completes.
- map_rd_en, out, 1, map RAM read strobe.
- map_addr, out, ADDR_W, map RAM address = row*MAP_W + col.
- map_data, in, 3, sprite id; valid the cycle after map_rd_en (registered RAM, 1-cycle latency).
- x_out, out, 8, pixel x of current tile.
- y_out, out, 7, pixel y of current tile.
- sprite_id_out, out, 3, sprite id of current tile.
- begin_draw, out, 1, one-cycle active-high draw request.
- draw_done, in, 1, one-cycle pulse from the drawer when a sprite is finished.

Behaviour:
- Reset (resetn low at a clk edge): state IDLE; col, row, map_addr, x_out, y_out and sprite_id_out all 0; busy, frame_done, map_rd_en and begin_draw all 0. Reset mid-frame abandons the frame and issues no further begin_draw. A drawer already in progress is not aborted by this block.
- Column, row and address are tracked by running counters. No multiplier: addr increments by 1 per tile, and x/y are built from col<<TILE_SHIFT and row<<TILE_SHIFT plus the origin.
- x/y arithmetic is truncated to 8/7 bits. Parameter legality is X_ORIGIN + MAP_W<<TILE_SHIFT <= 160 and Y_ORIGIN + MAP_H<<TILE_SHIFT <= 120. The bench checks this legality; the RTL does not.
- FSM states: IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, ADVANCE, FINISH.
- IDLE: on start=1 -> FETCH, with col=row=addr=0.
- FETCH: map_rd_en=1 for one cycle with map_addr=addr -> LATCH.
- LATCH: capture map_data into sprite_id_out and compute x_out/y_out in the same edge.
  - If map_data==SKIP_ID -> ADVANCE; no begin_draw and outputs not updated.
  - Otherwise -> ISSUE.
- ISSUE: begin_draw=1 for exactly one cycle -> WAIT_DONE. x_out, y_out and sprite_id_out stay stable from ISSUE until the next LATCH that does not skip.
- WAIT_DONE: hold until draw_done=1, then -> ADVANCE. draw_done is ignored in every other state, including the ISSUE cycle itself. There is no timeout.
- ADVANCE:
  - If col==MAP_W-1 and row==MAP_H-1 -> FINISH.
  - Else if col==MAP_W-1: col=0, row+=1.
  - Else col+=1.
  - In both non-final cases addr+=1 and -> FETCH.
- FINISH: frame_done=1 for one cycle -> IDLE.
- start while busy: ignored, not queued.
- Latency: start sampled at edge 0 gives map_rd_en in cycle 1, LATCH in cycle 2, begin_draw in cycle 3. draw_done at edge n gives the next map_rd_en at n+2.
- A frame whose tiles are all SKIP_ID takes 3 cycles per tile plus FINISH, and never asserts begin_draw.

Decomposition:
- Shared package sokoban_pkg holds:
  - Sprite id constants: FLOOR=0, WALL=1, GOAL=2, BOX=3, BOX_ON_GOAL=4, PLAYER=5, PLAYER_ON_GOAL=6, EMPTY=7.
  - Screen limits: 160x120.
  - FSM state encoding.
- SKIP_ID defaults to EMPTY from the package.
- One sub-module is natural: tile_cursor, holding the col/row/addr counters with a wrap flag and a last_tile flag. The FSM stays in the top module.

Test Plan:
- Basic frame: MAP_W=2, MAP_H=2, map={1,5,3,2}, drawer model returns draw_done 4 cycles after begin_draw. Required: exactly 4 begin_draw pulses with (x,y,id) = (0,0,1), (8,0,5), (0,8,3), (8,8,2); then one frame_done; busy drops the same cycle IDLE is re-entered.
- Latency: start at cycle 0. Required: map_rd_en=1, addr=0 at cycle 1; begin_draw at cycle 3. draw_done at cycle 10 gives map_rd_en, addr=1 at cycle 12.
- Skip: map={7,0,7,4}. Required: begin_draw only for (8,0,0) and (8,8,4); frame_done still pulses once.
- Protocol robustness: draw_done held high through ISSUE and pulsed spuriously in IDLE; start pulsed while busy. Required: no state advance from the ISSUE-cycle draw_done, no second frame, tile order unchanged.
- Reset mid-frame: resetn low during WAIT_DONE of tile 2. Required: next cycle all outputs 0 and state IDLE; a new start re-renders from addr 0.
- Origin/size: X_ORIGIN=16, Y_ORIGIN=8, MAP_W=18, MAP_H=14. Required: last tile at x=152, y=112, addr=251; frame_done after 252 draws.
